// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and forwarding-select encodings for the pipeline
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int RA_W = 5;
  localparam int CTRL_W = 8;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_calc.sv
// fwd_sel_calc: picks the youngest in-flight producer of one source register
module fwd_sel_calc #(
  parameter int RA_W = pipe_pkg::RA_W
) (
  input  logic [RA_W-1:0] src,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  output logic [1:0]      sel
);
  import pipe_pkg::*;
  // r0 never forwards; the ID/EX producer (next in EX/MEM) outranks EX/MEM (next in MEM/WB)
  always_comb
    sel = (src == '0) ? FWD_RF :
          (ex_valid && ex_regwrite && ex_rd == src) ? FWD_EXMEM :
          (mem_regwrite && mem_rd == src) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: ID/EX register with registered forwarding selects and load-use bubbles
module id_ex_fwd_stage #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RA_W   = pipe_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [DATA_W-1:0] id_opa,
  input  logic [DATA_W-1:0] id_opb,
  input  logic [7:0]        id_ctrl,
  input  logic              flush,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_regwrite,
  output logic              stall,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic [7:0]        ex_ctrl,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
);
  logic              valid_q, valid_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [1:0]        fa_q, fa_d, fb_q, fb_d;
  logic [1:0]        sel_a, sel_b;
  logic              bubble;

  fwd_sel_calc #(.RA_W(RA_W)) u_fwd_a (
    .src(id_rs), .ex_valid(valid_q), .ex_regwrite(regwrite_q), .ex_rd(rd_q),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .sel(sel_a)
  );

  fwd_sel_calc #(.RA_W(RA_W)) u_fwd_b (
    .src(id_rt), .ex_valid(valid_q), .ex_regwrite(regwrite_q), .ex_rd(rd_q),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .sel(sel_b)
  );

  // load in EX whose result a valid ID instruction needs: hold upstream, insert a bubble
  always_comb begin
    stall      = valid_q && memread_q && rd_q != '0 && id_valid && (rd_q == id_rs || rd_q == id_rt);
    bubble     = stall || flush || !id_valid;
    valid_d    = !bubble;
    rd_d       = bubble ? '0 : id_rd;
    regwrite_d = !bubble && id_regwrite;
    memread_d  = !bubble && id_memread;
    opa_d      = bubble ? '0 : id_opa;
    opb_d      = bubble ? '0 : id_opb;
    ctrl_d     = bubble ? '0 : id_ctrl;
    fa_d       = bubble ? 2'b00 : sel_a;
    fb_d       = bubble ? 2'b00 : sel_b;
  end

  // pipeline register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      ctrl_q     <= '0;
      fa_q       <= 2'b00;
      fb_q       <= 2'b00;
    end else begin
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      ctrl_q     <= ctrl_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
    end

  assign ex_valid    = valid_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_opa      = opa_q;
  assign ex_opb      = opb_q;
  assign ex_ctrl     = ctrl_q;
  assign fwd_a_sel   = fa_q;
  assign fwd_b_sel   = fb_q;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// tb_id_ex_fwd_stage: directed plus randomized checks against an instruction-level model
module tb_id_ex_fwd_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0, mem_regwrite = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, mem_rd = '0;
  logic [31:0] id_opa = '0, id_opb = '0;
  logic [7:0]  id_ctrl = '0;
  logic        stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic [31:0] ex_opa, ex_opb;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int n_pass = 0, n_tot = 0;

  typedef struct {
    bit         valid, rw, mr;
    bit [4:0]   rd;
    bit [31:0]  opa, opb;
    bit [7:0]   ctrl;
    bit [1:0]   fa, fb;
  } instr_t;
  instr_t m;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_opa(id_opa), .id_opb(id_opb),
    .id_ctrl(id_ctrl), .flush(flush), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .stall(stall), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_ctrl(ex_ctrl),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // which stage holds the most recent writer of register s, as seen by the next instruction
  function automatic bit [1:0] source_of(input bit [4:0] s);
    if (s == 0) return 2'd0;
    if (m.valid && m.rw && m.rd == s) return 2'd1;
    if (mem_regwrite && mem_rd == s) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit want_stall();
    return m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
    chk({tag, ".ex_regwrite"}, 32'(ex_regwrite), 32'(m.rw));
    chk({tag, ".ex_memread"}, 32'(ex_memread), 32'(m.mr));
    chk({tag, ".ex_opa"}, ex_opa, m.opa);
    chk({tag, ".ex_opb"}, ex_opb, m.opb);
    chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
    chk({tag, ".fwd_a"}, 32'(fwd_a_sel), 32'(m.fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b_sel), 32'(m.fb));
  endtask

  task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                       input bit rw, input bit mr, input bit fl, input bit [4:0] mrd, input bit mrw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_regwrite = rw; id_memread = mr;
    flush = fl; mem_rd = mrd; mem_regwrite = mrw;
    id_opa = $urandom; id_opb = $urandom; id_ctrl = 8'($urandom);
  endtask

  // check stall combinationally, clock once, advance the model, check registered outputs
  task automatic step(input string tag);
    instr_t n;
    bit kill;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(want_stall()));
    kill = want_stall() || flush || !id_valid;
    n = '{default: 0};
    if (!kill) begin
      n.valid = 1; n.rd = id_rd; n.rw = id_regwrite; n.mr = id_memread;
      n.opa = id_opa; n.opb = id_opb; n.ctrl = id_ctrl;
      n.fa = source_of(id_rs); n.fb = source_of(id_rt);
    end
    @(posedge clk);
    m = n;
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    m = '{default: 0};
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    check_outputs(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    m = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    // EX/MEM forwarding
    drive(1, 1, 2, 3, 1, 0, 0, 0, 0); step("exmem_prod");
    drive(1, 3, 1, 4, 1, 0, 0, 0, 0); step("exmem_cons");
    chk("exmem_a_const", 32'(fwd_a_sel), 32'd1);
    chk("exmem_b_const", 32'(fwd_b_sel), 32'd0);
    // MEM/WB forwarding and priority
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0); step("memwb_pad");
    drive(1, 1, 5, 6, 1, 0, 0, 5, 1); step("memwb_cons");
    chk("memwb_b_const", 32'(fwd_b_sel), 32'd2);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0); step("prio_prod");
    drive(1, 5, 5, 6, 1, 0, 0, 5, 1); step("prio_cons");
    chk("prio_a_const", 32'(fwd_a_sel), 32'd1);
    chk("prio_b_const", 32'(fwd_b_sel), 32'd1);
    // load-use stall, bubble, re-presented instruction
    drive(1, 1, 2, 7, 1, 1, 0, 0, 0); step("lu_load");
    drive(1, 7, 2, 8, 1, 0, 0, 0, 0);
    #1 chk("lu_stall_const", 32'(stall), 32'd1);
    step("lu_bubble");
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    id_rs = 7; id_rt = 2; id_rd = 8; mem_rd = 7; mem_regwrite = 1;
    step("lu_replay");
    chk("lu_replay_a_const", 32'(fwd_a_sel), 32'd2);
    // register zero
    drive(1, 1, 2, 0, 1, 1, 0, 0, 0); step("r0_load");
    drive(1, 0, 0, 4, 1, 0, 0, 0, 1);
    #1 chk("r0_stall_const", 32'(stall), 32'd0);
    step("r0_cons");
    chk("r0_a_const", 32'(fwd_a_sel), 32'd0);
    // flush, alone and together with a stall
    drive(1, 3, 3, 4, 1, 0, 1, 0, 0); step("flush");
    chk("flush_valid_const", 32'(ex_valid), 32'd0);
    drive(1, 1, 1, 2, 1, 1, 0, 0, 0); step("fl_load");
    drive(1, 2, 3, 4, 1, 0, 1, 0, 0); step("flush_stall");
    chk("flush_stall_ctrl_const", 32'(ex_ctrl), 32'd0);
    // async reset mid-stream with a load in EX
    drive(1, 1, 1, 6, 1, 1, 0, 0, 0); step("pre_reset");
    drive(1, 6, 0, 1, 1, 0, 0, 0, 0);
    async_reset("mid_reset");
    // randomized traffic over a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0,
            5'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 79) == 0) async_reset("rand_reset");
      else step("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
